// File: rtl/ram_port_master.sv
// ram_port_master
// ---------------------------------------------------------------------------
// Burst initiator for a single-port RAM with synchronous write and
// combinational read. A client issues a burst command (write or read, start
// address, beat count minus one) over a valid/ready handshake. Write beats
// stream in over wr_valid/wr_ready and go straight to the RAM. Read beats are
// captured into a one-entry output buffer and leave over rd_valid/rd_ready
// with backpressure.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr, cmd_len    burst type, start address, beats-1
//   wr_valid/wr_ready, wr_data      write beat stream
//   rd_valid/rd_ready, rd_data      read beat stream
//   done                            one-cycle pulse after a burst's last beat
//   ram_we, ram_addr, ram_wdata     RAM request side
//   ram_rdata                       RAM read data (combinational on ram_addr)
// ---------------------------------------------------------------------------
module ram_port_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    done_q, done_d;

    // Ungated versions of the request-side strobes; the ports are forced low
    // while reset is asserted so nothing reaches the RAM during an abort.
    logic                    cmd_ready_c;
    logic                    wr_ready_c;
    logic                    ram_we_c;
    logic [DATA_WIDTH-1:0]   ram_wdata_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        done_d      = 1'b0;
        cmd_ready_c = 1'b0;
        wr_ready_c  = 1'b0;
        ram_we_c    = 1'b0;
        ram_wdata_c = '0;

        // The output buffer drains in any state; a beat left over from the
        // previous read burst may still be pending in IDLE or WRITE.
        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? WRITE : READ;
                end
            end

            WRITE: begin
                wr_ready_c  = 1'b1;
                ram_we_c    = wr_valid;
                ram_wdata_c = wr_data;
                if (wr_valid) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            READ: begin
                // Capture whenever the buffer is empty or being emptied this
                // edge, which gives one beat per cycle under rd_ready = 1.
                if (!rd_valid_q || rd_ready) begin
                    rd_data_d  = ram_rdata;
                    rd_valid_d = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_c & rst_n;
    assign wr_ready  = wr_ready_c & rst_n;
    assign ram_we    = ram_we_c & rst_n;
    assign ram_wdata = rst_n ? ram_wdata_c : '0;
    assign ram_addr  = addr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ram_port_master.sv
// Directed bench for ram_port_master with a behavioural single-port RAM
// (synchronous write, combinational read) attached to the RAM side.
module tb_ram_port_master;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [16];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    ram_port_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .done      (done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rd_ready pattern and expected buffer contents after each edge of the
    // backpressured read of mem[3..6] = A1..A4.
    logic          bp_rr   [11] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1};
    logic          bp_rv   [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [DW-1:0] bp_data [11] = '{8'hA1, 8'hA1, 8'hA1, 8'hA2, 8'hA2, 8'hA2,
                                    8'hA3, 8'hA3, 8'hA3, 8'hA4, 8'hA4};
    logic          bp_done [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_addr", ram_addr, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // ---------------- write burst addr 3, len 3 ----------------
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd3; cmd_len = 4'd3;
        #1;
        chk("idle_ram_we", ram_we, 0);
        tick();
        cmd_valid = 1'b0;
        chk("wr_cmd_ready_busy", cmd_ready, 0);
        chk("wr_wr_ready", wr_ready, 1);
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'hA1 + i);
            #1;
            chk("wr_ram_we", ram_we, 1);
            chk("wr_ram_addr", ram_addr, 32'(3 + i));
            chk("wr_ram_wdata", ram_wdata, 32'(8'hA1 + i));
            chk("wr_done_early", done, 0);
            tick();
        end
        wr_valid = 1'b0;
        chk("wr_done", done, 1);
        chk("wr_back_idle", cmd_ready, 1);
        tick();
        chk("wr_done_one_cycle", done, 0);
        for (int i = 0; i < 4; i++) chk("wr_mem", mem[3 + i], 32'(8'hA1 + i));
        $display("txn write addr=3 len=3 done");

        // ---------------- read burst, rd_ready = 1 ----------------
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd3; cmd_len = 4'd3;
        rd_ready  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("rd_first_not_yet", rd_valid, 0);
        chk("rd_ram_addr", ram_addr, 3);
        #1;
        chk("rd_ram_we", ram_we, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, 32'(8'hA1 + i));
            chk("rd_done", done, (i == 3) ? 1 : 0);
        end
        tick();
        chk("rd_drained", rd_valid, 0);
        chk("rd_done_one_cycle", done, 0);
        $display("txn read addr=3 len=3 done");

        // ---------------- read with backpressure ----------------
        rd_ready  = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd3; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            rd_ready = bp_rr[i];
            tick();
            chk("bp_rd_valid", rd_valid, 32'(bp_rv[i]));
            chk("bp_rd_data", rd_data, 32'(bp_data[i]));
            chk("bp_done", done, 32'(bp_done[i]));
        end
        rd_ready = 1'b0;
        $display("txn read backpressure addr=3 len=3 done");

        // ---------------- wrap write addr 14, len 3 ----------------
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd14; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + i);
            #1;
            chk("wrap_ram_addr", ram_addr, 32'((14 + i) % 16));
            tick();
        end
        wr_valid = 1'b0;
        chk("wrap_done", done, 1);
        chk("wrap_mem14", mem[14], 8'h10);
        chk("wrap_mem15", mem[15], 8'h11);
        chk("wrap_mem0", mem[0], 8'h12);
        chk("wrap_mem1", mem[1], 8'h13);
        tick();
        $display("txn write wrap addr=14 len=3 done");

        rd_ready  = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd14; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_rd_valid", rd_valid, 1);
            chk("wrap_rd_data", rd_data, 32'(8'h10 + i));
        end
        tick();
        chk("wrap_rd_drained", rd_valid, 0);
        $display("txn read wrap addr=14 len=3 done");

        // ---------------- full depth write with stalls ----------------
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd0; cmd_len = 4'd15;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) begin
                wr_valid  = 1'b0;
                cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd5; cmd_len = 4'd0;
                #1;
                chk("full_gap_ram_we", ram_we, 0);
                chk("full_gap_cmd_ready", cmd_ready, 0);
                chk("full_gap_done", done, 0);
                tick();
                cmd_valid = 1'b0;
            end
            wr_valid = 1'b1;
            wr_data  = 8'(8'h40 + i);
            #1;
            chk("full_ram_we", ram_we, 1);
            chk("full_ram_addr", ram_addr, 32'(i));
            tick();
        end
        wr_valid = 1'b0;
        chk("full_done", done, 1);
        chk("full_cmd_ready", cmd_ready, 1);
        tick();
        chk("full_no_stray_read", rd_valid, 0);
        chk("full_idle", cmd_ready, 1);
        for (int i = 0; i < 16; i++) chk("full_mem", mem[i], 32'(8'h40 + i));
        $display("txn write full depth len=15 with stalls done");

        // ---------------- reset with a buffered read beat ----------------
        rd_ready  = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rstrd_buffered", rd_valid, 1);
        chk("rstrd_data", rd_data, 8'h40);
        rst_n = 1'b0;
        #1;
        chk("rstrd_rd_valid_cleared", rd_valid, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rstrd_cmd_ready", cmd_ready, 1);
        $display("txn reset during read done");

        // ---------------- reset mid write burst ----------------
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd8; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        wr_valid  = 1'b1;
        wr_data   = 8'hED;
        tick();
        wr_data = 8'hEE;
        rst_n   = 1'b0;
        #1;
        chk("rstwr_ram_we", ram_we, 0);
        chk("rstwr_wr_ready", wr_ready, 0);
        chk("rstwr_cmd_ready", cmd_ready, 0);
        tick();
        tick();
        chk("rstwr_mem8", mem[8], 8'hED);
        chk("rstwr_mem9_untouched", mem[9], 8'h49);
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        #1;
        chk("rstwr_post_cmd_ready", cmd_ready, 1);
        chk("rstwr_post_rd_valid", rd_valid, 0);
        chk("rstwr_post_done", done, 0);
        $display("txn reset during write done");

        // ---------------- read after reset ----------------
        rd_ready  = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd8; cmd_len = 4'd1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("post_rd0", rd_data, 8'hED);
        chk("post_rd0_valid", rd_valid, 1);
        tick();
        chk("post_rd1", rd_data, 8'h49);
        chk("post_rd1_done", done, 1);
        tick();
        chk("post_rd_drained", rd_valid, 0);
        $display("txn read addr=8 len=1 done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
